// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: 16-entry RS allocation tracking, age matrix and registered oldest-first issue grant.
// Ports: clk, rst (sync, active-high), rdy (global stall), clear (flush),
//   alloc_en/alloc_idx (dispatch write), ready_vec (per-entry operands ready), ex_ready (EX accepts),
//   free_idx/rs_full (combinational slot info), live_cnt, grant_valid/grant_idx (registered issue), alloc_err (sticky).
module rs_issue_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               alloc_en,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic [RS_SIZE-1:0] ready_vec,
  input  logic               ex_ready,
  output logic [IDX_W-1:0]   free_idx,
  output logic               rs_full,
  output logic [IDX_W:0]     live_cnt,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               alloc_err
);
  logic [RS_SIZE-1:0] live_vec;
  logic [RS_SIZE-1:0] age [RS_SIZE];
  logic [RS_SIZE-1:0] cand;
  logic [IDX_W-1:0]   sel_idx;
  logic               grant;
  logic               alloc_ok;
  logic               older;
  assign cand     = live_vec & ready_vec;
  assign grant    = ex_ready && (cand != '0);
  assign alloc_ok = alloc_en && !live_vec[alloc_idx];
  assign rs_full  = &live_vec;
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      free_idx = live_vec[i] ? free_idx : IDX_W'(i);
  end
  // The oldest candidate is the one no other candidate is older than.
  always_comb begin
    sel_idx = '0;
    older   = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      older = 1'b0;
      for (int j = 0; j < RS_SIZE; j++)
        older = older | (cand[j] & age[j][i]);
      sel_idx = (cand[i] && !older) ? IDX_W'(i) : sel_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      live_vec    <= '0;
      live_cnt    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      alloc_err   <= rst ? 1'b0 : alloc_err;
      for (int i = 0; i < RS_SIZE; i++)
        age[i] <= '0;
    end else if (rdy) begin
      grant_valid <= grant;
      grant_idx   <= grant ? sel_idx : grant_idx;
      live_cnt    <= live_cnt + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(grant);
      alloc_err   <= alloc_err | (alloc_en && !alloc_ok);
      for (int i = 0; i < RS_SIZE; i++)
        live_vec[i] <= (live_vec[i] && !(grant && sel_idx == IDX_W'(i))) || (alloc_ok && alloc_idx == IDX_W'(i));
      // The new entry is younger than every entry that survives this cycle.
      if (alloc_ok) begin
        age[alloc_idx] <= '0;
        for (int j = 0; j < RS_SIZE; j++)
          age[j][alloc_idx] <= live_vec[j] && !(grant && sel_idx == IDX_W'(j));
      end
    end
  end
endmodule
